mm_cdr_lockdet: RTL and testbench

Second-generation digital CDR loop filter with lock detection. It accepts a signed phase-error stream from an external Mueller-Müller phase detector and decimates it into blocks. A second-order, gain-switched, clamped loop drives NOUT phase-interpolator codes with per-output static offsets. It sits between the PD and the PI bank. Loop state is exposed to the JTAG debug domain through a 4-phase snapshot handshake.

---
 rtl/mm_cdr_lockdet.sv | 233 +++++++++++++++++++++++
 tb/tb_mm_cdr_lockdet.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_cdr_lockdet.sv
// Decimating second-order CDR loop filter with lock detection, driving a bank of PI codes.
// Loop state is readable from a slow debug domain through a 4-phase snapshot handshake.
module mm_cdr_lockdet #(
  parameter int unsigned PD_W     = 10,
  parameter int unsigned NPI      = 9,
  parameter int unsigned NOUT     = 4,
  parameter int unsigned PH_SHIFT = 20,
  parameter int unsigned G_W      = 5,
  parameter int unsigned LCNT_W   = 10
) (
  input  logic                      clk,
  input  logic                      ext_rstb,
  input  logic signed [PD_W-1:0]    pd_err,
  input  logic                      pd_valid,
  input  logic [2:0]                dec_log2,
  input  logic [G_W-1:0]            kp_acq,
  input  logic [G_W-1:0]            ki_acq,
  input  logic [G_W-1:0]            kp_lock,
  input  logic [G_W-1:0]            ki_lock,
  input  logic                      en_freq,
  input  logic                      hold,
  input  logic [NPI+PH_SHIFT-1:0]   clamp_amt,
  input  logic [PD_W+6:0]           lock_thr,
  input  logic [LCNT_W-1:0]         lock_len,
  input  logic [NPI-1:0]            pi_off [NOUT],
  input  logic                      ext_en,
  input  logic [NPI-1:0]            ext_pi,
  input  logic                      snap_req,
  output logic [NPI-1:0]            pi_ctl [NOUT],
  output logic                      locked,
  output logic [1:0]                lock_state,
  output logic                      snap_ack,
  output logic [NPI+PH_SHIFT-1:0]   snap_phase,
  output logic [NPI+PH_SHIFT-1:0]   snap_freq,
  output logic [1:0]                snap_state
);

  localparam int unsigned PH_W = NPI + PH_SHIFT;
  localparam int unsigned BW   = PD_W + 7;
  localparam int unsigned XW   = PH_W + G_W;

  localparam logic signed [PH_W-1:0] PMax   = {1'b0, {(PH_W-1){1'b1}}};
  localparam logic signed [XW-1:0]   PMaxX  = {{(G_W+1){1'b0}}, {(PH_W-1){1'b1}}};
  localparam logic [BW-1:0]          BlkMin = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0]          BlkMax = {1'b0, {(BW-1){1'b1}}};

  typedef enum logic [1:0] {
    StAcq    = 2'b00,
    StSlip   = 2'b01,
    StLocked = 2'b10
  } lock_st_e;

  function automatic logic signed [XW-1:0] sext(input logic signed [PH_W-1:0] v);
    return {{G_W{v[PH_W-1]}}, v};
  endfunction

  // Symmetric saturation keeps the most-negative code out of the loop.
  function automatic logic signed [PH_W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > PMaxX) begin
      return PMax;
    end else if (v < -PMaxX) begin
      return -PMax;
    end else begin
      return v[PH_W-1:0];
    end
  endfunction

  // ---------------- decimator ----------------
  logic signed [BW-1:0] err_sum_q, err_blk_q, pd_ext;
  logic [6:0]           cnt_q, cnt_last;
  logic [2:0]           dec_q, dec_eff;
  logic                 upd_q;

  always_comb begin
    pd_ext   = {{7{pd_err[PD_W-1]}}, pd_err};
    // A new block length is only adopted when a block starts.
    dec_eff  = (cnt_q == 7'd0) ? dec_log2 : dec_q;
    cnt_last = (7'd1 << dec_eff) - 7'd1;
  end

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      err_sum_q <= '0;
      err_blk_q <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (hold) begin
        err_sum_q <= '0;
        cnt_q     <= '0;
      end else if (pd_valid) begin
        if (cnt_q == 7'd0) dec_q <= dec_log2;
        if (cnt_q == cnt_last) begin
          err_blk_q <= err_sum_q + pd_ext;
          upd_q     <= 1'b1;
          err_sum_q <= '0;
          cnt_q     <= '0;
        end else begin
          err_sum_q <= err_sum_q + pd_ext;
          cnt_q     <= cnt_q + 7'd1;
        end
      end
    end
  end

  // ---------------- loop filter ----------------
  lock_st_e                state_q;
  logic signed [PH_W-1:0]  freq_q, freq_nxt, step_raw;
  logic [PH_W-1:0]         phase_q, phase_nxt;
  logic [G_W-1:0]          kp, ki;
  logic signed [XW-1:0]    blk_x, p_sh, i_sh, step_x, clamp_x;
  logic [LCNT_W-1:0]       gcnt_q, bcnt_q, llen;
  logic [LCNT_W:0]         gcnt_inc, bcnt_inc;
  logic [BW-1:0]           blk_abs;
  logic                    good;

  always_comb begin
    kp       = (state_q != StAcq) ? kp_lock : kp_acq;
    ki       = (state_q != StAcq) ? ki_lock : ki_acq;
    blk_x    = {{(XW-BW){err_blk_q[BW-1]}}, err_blk_q};
    p_sh     = blk_x <<< kp;
    i_sh     = en_freq ? (blk_x <<< ki) : '0;
    freq_nxt = sat(sext(freq_q) + sext(sat(i_sh)));
    // The proportional step uses the integrator value from before this update.
    step_raw = sat(sext(sat(p_sh)) + sext(freq_q));
    step_x   = sext(step_raw);
    clamp_x  = {{G_W{1'b0}}, clamp_amt};
    if (clamp_amt != '0) begin
      if (step_x > clamp_x) begin
        step_x = clamp_x;
      end else if (step_x < -clamp_x) begin
        step_x = -clamp_x;
      end
    end
    phase_nxt = phase_q + step_x[PH_W-1:0];

    if (err_blk_q == BlkMin) begin
      blk_abs = BlkMax;
    end else if (err_blk_q[BW-1]) begin
      blk_abs = ~err_blk_q + 1'b1;
    end else begin
      blk_abs = err_blk_q;
    end
    good     = (blk_abs <= lock_thr);
    llen     = (lock_len == '0) ? LCNT_W'(1) : lock_len;
    gcnt_inc = {1'b0, gcnt_q} + (LCNT_W+1)'(1);
    bcnt_inc = {1'b0, bcnt_q} + (LCNT_W+1)'(1);
  end

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      freq_q  <= '0;
      phase_q <= '0;
      state_q <= StAcq;
      gcnt_q  <= '0;
      bcnt_q  <= '0;
    end else if (upd_q && !hold) begin
      freq_q  <= freq_nxt;
      phase_q <= phase_nxt;
      unique case (state_q)
        StAcq: begin
          if (!good) begin
            gcnt_q <= '0;
          end else if (gcnt_inc >= {1'b0, llen}) begin
            gcnt_q  <= '0;
            state_q <= StLocked;
          end else begin
            gcnt_q <= gcnt_inc[LCNT_W-1:0];
          end
        end
        StLocked: begin
          if (!good) begin
            state_q <= StSlip;
            bcnt_q  <= LCNT_W'(1);
          end
        end
        StSlip: begin
          if (good) begin
            state_q <= StLocked;
            bcnt_q  <= '0;
          end else if (bcnt_inc >= {1'b0, llen}) begin
            state_q <= StAcq;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
          end else begin
            bcnt_q <= bcnt_inc[LCNT_W-1:0];
          end
        end
        default: state_q <= StAcq;
      endcase
    end
  end

  assign lock_state = state_q;
  assign locked     = (state_q != StAcq);

  // ---------------- PI outputs ----------------
  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      for (int k = 0; k < int'(NOUT); k++) pi_ctl[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NOUT); k++) begin
        pi_ctl[k] <= ext_en ? ext_pi : (phase_q[PH_W-1:PH_SHIFT] + pi_off[k]);
      end
    end
  end

  // ---------------- snapshot handshake ----------------
  logic snap_req_q;

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      snap_req_q <= 1'b0;
      snap_ack   <= 1'b0;
      snap_phase <= '0;
      snap_freq  <= '0;
      snap_state <= '0;
    end else begin
      snap_req_q <= snap_req;
      if (snap_req && !snap_req_q && !snap_ack) begin
        snap_ack   <= 1'b1;
        snap_phase <= phase_q;
        snap_freq  <= freq_q;
        snap_state <= state_q;
      end else if (!snap_req) begin
        snap_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mm_cdr_lockdet.sv
// Directed bench for mm_cdr_lockdet: decimation, integral path, wrap, clamp, lock FSM, snapshot.
module tb_mm_cdr_lockdet;

  logic              clk;
  logic              ext_rstb;
  logic signed [9:0] pd_err;
  logic              pd_valid;
  logic [2:0]        dec_log2;
  logic [4:0]        kp_acq, ki_acq, kp_lock, ki_lock;
  logic              en_freq, hold;
  logic [28:0]       clamp_amt;
  logic [16:0]       lock_thr;
  logic [9:0]        lock_len;
  logic [8:0]        pi_off [4];
  logic              ext_en;
  logic [8:0]        ext_pi;
  logic              snap_req;
  logic [8:0]        pi_ctl [4];
  logic              locked;
  logic [1:0]        lock_state;
  logic              snap_ack;
  logic [28:0]       snap_phase, snap_freq;
  logic [1:0]        snap_state;

  int n_cmp = 0;
  int n_err = 0;

  mm_cdr_lockdet dut (
    .clk        (clk),
    .ext_rstb   (ext_rstb),
    .pd_err     (pd_err),
    .pd_valid   (pd_valid),
    .dec_log2   (dec_log2),
    .kp_acq     (kp_acq),
    .ki_acq     (ki_acq),
    .kp_lock    (kp_lock),
    .ki_lock    (ki_lock),
    .en_freq    (en_freq),
    .hold       (hold),
    .clamp_amt  (clamp_amt),
    .lock_thr   (lock_thr),
    .lock_len   (lock_len),
    .pi_off     (pi_off),
    .ext_en     (ext_en),
    .ext_pi     (ext_pi),
    .snap_req   (snap_req),
    .pi_ctl     (pi_ctl),
    .locked     (locked),
    .lock_state (lock_state),
    .snap_ack   (snap_ack),
    .snap_phase (snap_phase),
    .snap_freq  (snap_freq),
    .snap_state (snap_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ext_rstb = 1'b0;
    step(1);
    ext_rstb = 1'b1;
    step(1);
  endtask

  // One single-sample block (dec_log2 = 0), then let phase and FSM settle.
  task automatic send(input logic signed [9:0] e);
    pd_err   = e;
    pd_valid = 1'b1;
    step(1);
    pd_valid = 1'b0;
    step(2);
  endtask

  task automatic snap(input string tag, input logic [63:0] exp_ph, input logic [63:0] exp_fr);
    snap_req = 1'b1;
    step(1);
    chk({tag, "_ack"}, 64'(snap_ack), 64'd1);
    chk({tag, "_phase"}, 64'(snap_phase), exp_ph);
    chk({tag, "_freq"}, 64'(snap_freq), exp_fr);
    snap_req = 1'b0;
    step(1);
    chk({tag, "_ackclr"}, 64'(snap_ack), 64'd0);
  endtask

  initial begin
    ext_rstb = 1'b0;
    pd_err = '0; pd_valid = 1'b0; dec_log2 = 3'd2;
    kp_acq = 5'd4; ki_acq = 5'd2; kp_lock = 5'd1; ki_lock = 5'd0;
    en_freq = 1'b0; hold = 1'b0; clamp_amt = '0; lock_thr = '0; lock_len = 10'd3;
    for (int k = 0; k < 4; k++) pi_off[k] = '0;
    ext_en = 1'b0; ext_pi = '0; snap_req = 1'b0;
    #12;
    chk("rst_pi0", 64'(pi_ctl[0]), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_state", 64'(lock_state), 64'd0);
    chk("rst_ack", 64'(snap_ack), 64'd0);
    chk("rst_snap_phase", 64'(snap_phase), 64'd0);
    ext_rstb = 1'b1;
    step(1);

    // Decimate by 4: two blocks of 12, each step 12<<4 = 192.
    pd_err = 10'sd3; pd_valid = 1'b1;
    step(8);
    pd_valid = 1'b0;
    step(3);
    snap("dec4", 64'd384, 64'd0);
    chk("dec4_pi0", 64'(pi_ctl[0]), 64'd0);
    // Length change mid-block applies after the current 4-sample block.
    pd_err = 10'sd1; pd_valid = 1'b1;
    step(2);
    dec_log2 = 3'd0;
    step(3);
    pd_valid = 1'b0;
    step(3);
    snap("decchg", 64'd464, 64'd0);

    // Integral path, step uses previous freq: 1+0, 1+4, 1+8.
    do_reset();
    dec_log2 = 3'd0; kp_acq = 5'd0; ki_acq = 5'd2; en_freq = 1'b1; pd_err = 10'sd1;
    pd_valid = 1'b1;
    step(3);
    pd_valid = 1'b0;
    step(3);
    snap("freq", 64'd15, 64'd12);
    // Integrator saturation: 511<<19 twice exceeds 2^28-1.
    do_reset();
    ki_acq = 5'd19;
    send(10'sd511);
    snap("fsat1", 64'd511, 64'd267911168);
    send(10'sd511);
    send(10'sd511);
    chk("fsat_state", 64'(lock_state), 64'd0);
    pd_valid = 1'b0;
    snap_req = 1'b1;
    step(1);
    chk("fsat_max", 64'(snap_freq), 64'd268435455);
    snap_req = 1'b0;
    step(1);

    // Phase wrap through zero, PI latency and offsets.
    en_freq = 1'b0; kp_acq = 5'd4; pi_off[1] = 9'd5;
    do_reset();
    pd_err = -10'sd1; pd_valid = 1'b1;
    step(1);
    pd_valid = 1'b0;
    step(1);
    chk("pi_latency", 64'(pi_ctl[0]), 64'd0);
    step(1);
    chk("wrap_pi0_hi", 64'(pi_ctl[0]), 64'd511);
    chk("wrap_pi1_hi", 64'(pi_ctl[1]), 64'd4);
    send(10'sd2);
    chk("wrap_pi0_lo", 64'(pi_ctl[0]), 64'd0);
    chk("wrap_pi1_lo", 64'(pi_ctl[1]), 64'd5);
    snap("wrap", 64'd16, 64'd0);
    ext_en = 1'b1; ext_pi = 9'd123;
    step(1);
    chk("ext_pi2", 64'(pi_ctl[2]), 64'd123);
    ext_en = 1'b0;
    step(1);
    chk("ext_off_pi1", 64'(pi_ctl[1]), 64'd5);
    pi_off[1] = 9'd0;

    // Clamp: +/-4800 limited to +/-100.
    do_reset();
    clamp_amt = 29'd100;
    send(10'sd300);
    snap("clamp_pos", 64'd100, 64'd0);
    send(-10'sd300);
    send(-10'sd300);
    snap("clamp_neg", 64'd536870812, 64'd0);
    clamp_amt = '0;

    // Lock FSM with gain switch (kp 4 in ACQ, 1 otherwise).
    do_reset();
    lock_thr = 17'd2; lock_len = 10'd3;
    send(10'sd1);
    send(10'sd1);
    chk("acq_2good", 64'(lock_state), 64'd0);
    send(10'sd1);
    chk("lock_state", 64'(lock_state), 64'd2);
    chk("lock_flag", 64'(locked), 64'd1);
    send(10'sd9);
    chk("slip_state", 64'(lock_state), 64'd1);
    chk("slip_locked", 64'(locked), 64'd1);
    send(10'sd1);
    chk("relock", 64'(lock_state), 64'd2);
    snap("gain_lock", 64'd68, 64'd0);
    chk("snap_state_lk", 64'(snap_state), 64'd2);
    send(10'sd9);
    send(10'sd9);
    chk("slip_2bad", 64'(lock_state), 64'd1);
    send(10'sd9);
    chk("unlock_state", 64'(lock_state), 64'd0);
    chk("unlock_flag", 64'(locked), 64'd0);
    send(10'sd1);
    snap("gain_acq", 64'd138, 64'd0);
    lock_thr = '0;

    // Snapshot while an update lands, ack hold, re-raise; then hold discards blocks.
    do_reset();
    send(10'sd1);
    pd_err = 10'sd2; pd_valid = 1'b1;
    step(1);
    pd_valid = 1'b0; snap_req = 1'b1;
    step(1);
    chk("snap_upd_ack", 64'(snap_ack), 64'd1);
    chk("snap_upd_pre", 64'(snap_phase), 64'd16);
    step(1);
    chk("snap_ack_held", 64'(snap_ack), 64'd1);
    snap_req = 1'b0;
    step(1);
    chk("snap_ack_drop", 64'(snap_ack), 64'd0);
    snap("snap_new", 64'd48, 64'd0);
    pd_err = 10'sd5; pd_valid = 1'b1;
    step(1);
    pd_valid = 1'b0; hold = 1'b1;
    step(1);
    hold = 1'b0;
    step(2);
    snap("hold_upd", 64'd48, 64'd0);
    hold = 1'b1; pd_valid = 1'b1;
    step(3);
    hold = 1'b0; pd_valid = 1'b0;
    step(3);
    snap("hold_acc", 64'd48, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
